wb_bus_arbiter: RTL and testbench

- Round-robin Wishbone bus arbiter that shares one node-side bus among up to N_MASTERS requesters, e.g. a local master and a NIC master port.
- Generates the per-master gnt_wb_i grants that NIC instances and fake masters consume.
- Replaces ad-hoc grant generation driven from CYC edges.
- Grants are registered and one-hot. A grant is held for the whole CYC cycle of its owner, followed by a one-cycle turnaround.

---
 rtl/wb_bus_arbiter_if.sv | 28 ++
 rtl/wb_bus_arbiter.sv | 119 +++++++++++
 tb/tb_wb_bus_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_if.sv
// Arbiter bus bundle: per-master CYC requests in, one-hot grants and owner status out.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface wb_bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ID_WIDTH  = 1
);
  logic [N_MASTERS-1:0] cyc_i;
  logic [N_MASTERS-1:0] gnt_o;
  logic [ID_WIDTH-1:0]  gnt_id_o;
  logic                 bus_busy_o;
  logic                 timeout_o;

  modport slave (
    input  cyc_i,
    output gnt_o,
    output gnt_id_o,
    output bus_busy_o,
    output timeout_o
  );

  modport master (
    output cyc_i,
    input  gnt_o,
    input  gnt_id_o,
    input  bus_busy_o,
    input  timeout_o
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: registered one-hot grants held for a whole CYC, then one TURN cycle.
// Optional watchdog release and per-master masking enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int ID_WIDTH       = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic            clk,
  input logic            rst,
  wb_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t               state;
  logic [N_MASTERS-1:0] gnt;
  logic [ID_WIDTH-1:0]  gnt_id;
  logic                 busy;
  logic                 timeout;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [N_MASTERS-1:0] req;
  logic [ID_WIDTH-1:0]  winner;
  logic [ID_WIDTH-1:0]  next_ptr;
  logic                 owner_cyc;

  // First requester at or above ptr, wrapping modulo N_MASTERS.
  function automatic logic [ID_WIDTH-1:0] pick(input logic [N_MASTERS-1:0] r,
                                               input logic [ID_WIDTH-1:0]  ptr);
    logic [ID_WIDTH-1:0] w;
    logic [ID_WIDTH-1:0] cand;
    logic                found;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = ID_WIDTH'((int'(ptr) + i) % N_MASTERS);
      if (!found && r[cand]) begin
        w     = cand;
        found = 1'b1;
      end
    end
    return w;
  endfunction

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [N_MASTERS-1:0] mask;
  logic [CNT_W-1:0]     cnt;
  assign req = bus.cyc_i & ~mask;
`else
  assign req = bus.cyc_i;
`endif

  assign winner    = pick(req, rr_ptr);
  assign owner_cyc = bus.cyc_i[gnt_id];
  assign next_ptr  = (gnt_id == ID_WIDTH'(N_MASTERS - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      rr_ptr  <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      mask    <= '0;
      cnt     <= '0;
`endif
    end else begin
      timeout <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      // A master sampled with CYC low is eligible again.
      mask    <= mask & bus.cyc_i;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            gnt    <= N_MASTERS'(1) << winner;
            gnt_id <= winner;
            busy   <= 1'b1;
            state  <= GRANT;
`ifdef WB_ARB_TIMEOUT_EN
            cnt    <= '0;
`endif
          end
        end
        GRANT: begin
          if (!owner_cyc) begin
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= TURN;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog: forced release; owner stays masked until it drops CYC.
            gnt     <= '0;
            busy    <= 1'b0;
            rr_ptr  <= next_ptr;
            timeout <= 1'b1;
            mask    <= (mask & bus.cyc_i) | (N_MASTERS'(1) << gnt_id);
            state   <= TURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.gnt_id_o   = gnt_id;
  assign bus.bus_busy_o = busy;
  assign bus.timeout_o  = timeout;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: table-driven 2-master vectors plus 4-master and watchdog sequences.
module tb_wb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic mon_on = 1'b0;

  always #5 clk = ~clk;

  wb_bus_arbiter_if #(.N_MASTERS(2), .ID_WIDTH(1)) bus2 ();
  wb_bus_arbiter_if #(.N_MASTERS(4), .ID_WIDTH(2)) bus4 ();

  wb_bus_arbiter #(.N_MASTERS(2), .ID_WIDTH(1), .TIMEOUT_CYCLES(16)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));
  wb_bus_arbiter #(.N_MASTERS(4), .ID_WIDTH(2), .TIMEOUT_CYCLES(16)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] gnt;
    logic       id;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [1:0] c, input logic [1:0] g,
                     input logic i, input logic b);
    vec_t v;
    v.rst = r; v.cyc = c; v.gnt = g; v.id = i; v.busy = b;
    vt.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [3:0] ag, input logic [1:0] aid, input logic ab, input logic at,
                     input logic [3:0] eg, input logic [1:0] eid, input logic eb, input logic et);
    total++;
    if (ag !== eg || aid !== eid || ab !== eb || at !== et) begin
      bad++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b timeout=%b, want gnt=%b id=%0d busy=%b timeout=%b",
               name, ag, aid, ab, at, eg, eid, eb, et);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] eg, input logic eid,
                      input logic eb, input logic et);
    chk(name, {2'b00, bus2.gnt_o}, {1'b0, bus2.gnt_id_o}, bus2.bus_busy_o, bus2.timeout_o,
        {2'b00, eg}, {1'b0, eid}, eb, et);
  endtask

  task automatic chk4(input string name, input logic [3:0] eg, input logic [1:0] eid,
                      input logic eb);
    chk(name, bus4.gnt_o, bus4.gnt_id_o, bus4.bus_busy_o, bus4.timeout_o, eg, eid, eb, 1'b0);
  endtask

  // Grants must never have more than one bit set.
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if ($countones(bus2.gnt_o) > 1 || $countones(bus4.gnt_o) > 1) begin
        bad++;
        $display("FAIL onehot: got gnt2=%b gnt4=%b, want at most one bit set", bus2.gnt_o, bus4.gnt_o);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus2.cyc_i = '0;
    bus4.cyc_i = '0;

    // reset, with and without a pending request
    add(1, 2'b00, 2'b00, 0, 0);
    add(1, 2'b01, 2'b00, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0);
    // master 0 holds CYC for 10 cycles
    for (int i = 0; i < 10; i++) add(0, 2'b01, 2'b01, 0, 1);
    add(0, 2'b00, 2'b00, 0, 0);   // release -> TURN, rr_ptr=1
    add(0, 2'b11, 2'b00, 0, 0);   // TURN -> IDLE, request ignored
    // both request: alternating 1,0,1 with 2-cycle gaps
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b10, 1, 1);
    add(0, 2'b01, 2'b00, 1, 0);
    add(0, 2'b11, 2'b00, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b01, 0, 1);
    add(0, 2'b10, 2'b00, 0, 0);
    add(0, 2'b11, 2'b00, 0, 0);
    add(0, 2'b11, 2'b10, 1, 1);
    add(0, 2'b01, 2'b00, 1, 0);
    // gnt_id holds while idle
    add(0, 2'b00, 2'b00, 1, 0);
    add(0, 2'b00, 2'b00, 1, 0);
    // reset while master 1 owns the bus
    add(0, 2'b10, 2'b10, 1, 1);
    add(0, 2'b10, 2'b10, 1, 1);
    add(1, 2'b11, 2'b00, 0, 0);
    add(0, 2'b11, 2'b01, 0, 1);   // rr_ptr back to 0: master 0 wins
    add(0, 2'b00, 2'b00, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0);
    // master 1 pulses CYC while 0 owns the bus: never served
    add(0, 2'b01, 2'b01, 0, 1);
    add(0, 2'b11, 2'b01, 0, 1);
    add(0, 2'b01, 2'b01, 0, 1);
    add(0, 2'b00, 2'b00, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0);

    foreach (vt[k]) begin
      rst        = vt[k].rst;
      bus2.cyc_i = vt[k].cyc;
      tick();
      mon_on = 1'b1;
      chk2($sformatf("vec%0d", k), vt[k].gnt, vt[k].id, vt[k].busy, 1'b0);
    end

    // 4 masters: move rr_ptr to 2, then 1010 picks 3, then 1 after wrap
    bus4.cyc_i = 4'b0010; tick(); chk4("n4_grant1",   4'b0010, 2'd1, 1'b1);
    bus4.cyc_i = 4'b0000; tick(); chk4("n4_rel1",     4'b0000, 2'd1, 1'b0);
    bus4.cyc_i = 4'b1010; tick(); chk4("n4_turn",     4'b0000, 2'd1, 1'b0);
    tick();                       chk4("n4_win3",     4'b1000, 2'd3, 1'b1);
    bus4.cyc_i = 4'b0010; tick(); chk4("n4_rel3",     4'b0000, 2'd3, 1'b0);
    tick();                       chk4("n4_turn2",    4'b0000, 2'd3, 1'b0);
    tick();                       chk4("n4_win1",     4'b0010, 2'd1, 1'b1);
    bus4.cyc_i = 4'b0000; tick(); chk4("n4_rel_last", 4'b0000, 2'd1, 1'b0);

`ifdef WB_ARB_TIMEOUT_EN
    // master 0 never drops CYC: forced release after 16 granted cycles
    bus2.cyc_i = 2'b01; tick(); chk2("to_grant0", 2'b01, 1'b0, 1'b1, 1'b0);
    bus2.cyc_i = 2'b11;
    for (int i = 1; i < 16; i++) begin
      tick(); chk2($sformatf("to_hold%0d", i), 2'b01, 1'b0, 1'b1, 1'b0);
    end
    tick(); chk2("to_pulse",  2'b00, 1'b0, 1'b0, 1'b1);
    tick(); chk2("to_idle",   2'b00, 1'b0, 1'b0, 1'b0);
    tick(); chk2("to_win1",   2'b10, 1'b1, 1'b1, 1'b0);
    bus2.cyc_i = 2'b01;
    tick(); chk2("to_rel1",   2'b00, 1'b1, 1'b0, 1'b0);
    tick(); chk2("to_turn",   2'b00, 1'b1, 1'b0, 1'b0);
    tick(); chk2("to_masked", 2'b00, 1'b1, 1'b0, 1'b0);
    tick(); chk2("to_masked2", 2'b00, 1'b1, 1'b0, 1'b0);
    bus2.cyc_i = 2'b00;
    tick(); chk2("to_unmask", 2'b00, 1'b1, 1'b0, 1'b0);
    bus2.cyc_i = 2'b01;
    tick(); chk2("to_regrant0", 2'b01, 1'b0, 1'b1, 1'b0);
    bus2.cyc_i = 2'b00;
    tick(); chk2("to_rel0",   2'b00, 1'b0, 1'b0, 1'b0);
`else
    // no watchdog: a 40-cycle tenure is held throughout with timeout_o low
    bus2.cyc_i = 2'b01; tick(); chk2("long_grant0", 2'b01, 1'b0, 1'b1, 1'b0);
    bus2.cyc_i = 2'b11;
    for (int i = 1; i < 40; i++) begin
      tick(); chk2($sformatf("long_hold%0d", i), 2'b01, 1'b0, 1'b1, 1'b0);
    end
    bus2.cyc_i = 2'b10;
    tick(); chk2("long_rel0", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); chk2("long_turn", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); chk2("long_win1", 2'b10, 1'b1, 1'b1, 1'b0);
`endif

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
